// File: rtl/instruction_fetch_decode.sv
// instruction_fetch_decode
//   Front-end stage of the multi-cycle core. Owns the PC, fetches one 32-bit
//   word per en_instruction_fetch pulse over a req/ack memory handshake, holds
//   it in the instruction register (IR), and registers its decoded fields onto
//   the outputs on each en_instruction_decode pulse taken in READY.
//
// Optional build macro: IMEM_TIMEOUT_EN adds the fetch_error output. A fetch
//   that sees no imem_ack for TIMEOUT_CYCLES REQ cycles then completes with an
//   R-type NOP (IR = 0) and raises fetch_error.
//
// Ports:
//   clock, reset_n            clock (rising edge), async active-low reset
//   en_instruction_fetch      pulse: start a fetch (ignored while in REQ)
//   en_instruction_decode     pulse: register the decoded IR fields (READY only)
//   sig_pc_src[1:0]           next PC: 0 PC+4, 1 branch, 2 jump, 3 return
//   branch_target, return_address   candidate next-PC values
//   imem_req, imem_addr       memory request and address (stable in REQ)
//   imem_ack, imem_rdata      memory acknowledge with same-cycle data
//   InstructionType, FunctionCode, rs1, rd, rs2, immediate, stop_bit
//                             registered decode outputs
//   pc_current, pc_plus4      address of the IR word and that address + 4
//   fetch_busy                high while in REQ
//   instruction_valid         high from acknowledge until the next fetch starts
//   fetch_error               (IMEM_TIMEOUT_EN only) the last fetch timed out
//   state_dbg                 current FSM state (0 IDLE, 1 REQ, 2 READY)
//
// Memory handshake: imem_req is high for every cycle spent in REQ and
//   imem_addr does not change while it is high. The transfer completes on the
//   first rising edge at which imem_req and imem_ack are both high, and
//   imem_rdata is captured on that edge. imem_ack is ignored at all other times.
module instruction_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IMEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en_instruction_fetch,
  input  logic        en_instruction_decode,
  input  logic [1:0]  sig_pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] return_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [1:0]  InstructionType,
  output logic [4:0]  FunctionCode,
  output logic [4:0]  rs1,
  output logic [4:0]  rd,
  output logic [4:0]  rs2,
  output logic [31:0] immediate,
  output logic        stop_bit,
  output logic [31:0] pc_current,
  output logic [31:0] pc_plus4,
  output logic        fetch_busy,
  output logic        instruction_valid,
`ifdef IMEM_TIMEOUT_EN
  output logic        fetch_error,
`endif
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        first_fetch;
  logic [31:0] jump_target;
  logic [31:0] fetch_addr;
  logic [31:0] imm_dec;

`ifdef IMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // imem_req comes straight from the state register, so an asynchronous
  // reset drops it without waiting for a clock edge.
  assign imem_req   = (state == S_REQ);
  assign fetch_busy = (state == S_REQ);
  assign state_dbg  = state;
  assign pc_plus4   = pc_current + 32'd4;

  // Jump offset is a signed word count taken from IR[26:3].
  assign jump_target = pc_current + {{6{ir[26]}}, ir[26:3], 2'b00};

  always_comb begin
    fetch_addr = pc;
    if (!first_fetch) begin
      case (sig_pc_src)
        2'd0:    fetch_addr = pc_plus4;
        2'd1:    fetch_addr = branch_target;
        2'd2:    fetch_addr = jump_target;
        default: fetch_addr = return_address;
      endcase
    end
  end

  always_comb begin
    imm_dec = 32'd0;
    case (ir[2:1])
      2'd1, 2'd2: imm_dec = {{18{ir[16]}}, ir[16:3]};
      2'd3:       imm_dec = {{8{ir[26]}}, ir[26:3]};
      default:    imm_dec = 32'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      pc                <= RESET_PC;
      ir                <= 32'd0;
      first_fetch       <= 1'b1;
      imem_addr         <= 32'd0;
      pc_current        <= RESET_PC;
      instruction_valid <= 1'b0;
      InstructionType   <= 2'd0;
      FunctionCode      <= 5'd0;
      rs1               <= 5'd0;
      rd                <= 5'd0;
      rs2               <= 5'd0;
      immediate         <= 32'd0;
      stop_bit          <= 1'b0;
`ifdef IMEM_TIMEOUT_EN
      tmo_cnt           <= '0;
      fetch_error       <= 1'b0;
`endif
    end else begin
      // Decode reads the IR as it stands before this edge, so a fetch
      // started on the same edge does not disturb it.
      if (en_instruction_decode && state == S_READY) begin
        InstructionType <= ir[2:1];
        FunctionCode    <= ir[31:27];
        rs1             <= ir[26:22];
        rd              <= ir[21:17];
        rs2             <= ir[16:12];
        immediate       <= imm_dec;
        stop_bit        <= ir[0];
      end

      case (state)
        S_IDLE, S_READY: begin
          if (en_instruction_fetch) begin
            pc                <= fetch_addr;
            imem_addr         <= fetch_addr;
            first_fetch       <= 1'b0;
            instruction_valid <= 1'b0;
            state             <= S_REQ;
`ifdef IMEM_TIMEOUT_EN
            tmo_cnt           <= '0;
            fetch_error       <= 1'b0;
`endif
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            ir                <= imem_rdata;
            pc_current        <= imem_addr;
            instruction_valid <= 1'b1;
            state             <= S_READY;
          end
`ifdef IMEM_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            // Complete with an R-type NOP so the control unit can proceed.
            ir                <= 32'd0;
            pc_current        <= imem_addr;
            instruction_valid <= 1'b1;
            fetch_error       <= 1'b1;
            state             <= S_READY;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_decode.sv
module tb_instruction_fetch_decode;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        en_instruction_fetch = 1'b0;
  logic        en_instruction_decode = 1'b0;
  logic [1:0]  sig_pc_src = 2'd0;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] return_address = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [1:0]  InstructionType;
  logic [4:0]  FunctionCode, rs1, rd, rs2;
  logic [31:0] immediate;
  logic        stop_bit;
  logic [31:0] pc_current, pc_plus4;
  logic        fetch_busy, instruction_valid;
  logic [1:0]  state_dbg;
`ifdef IMEM_TIMEOUT_EN
  logic        fetch_error;
`endif

  instruction_fetch_decode #(.RESET_PC(RESET_PC)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .en_instruction_fetch  (en_instruction_fetch),
    .en_instruction_decode (en_instruction_decode),
    .sig_pc_src            (sig_pc_src),
    .branch_target         (branch_target),
    .return_address        (return_address),
    .imem_req              (imem_req),
    .imem_addr             (imem_addr),
    .imem_ack              (imem_ack),
    .imem_rdata            (imem_rdata),
    .InstructionType       (InstructionType),
    .FunctionCode          (FunctionCode),
    .rs1                   (rs1),
    .rd                    (rd),
    .rs2                   (rs2),
    .immediate             (immediate),
    .stop_bit              (stop_bit),
    .pc_current            (pc_current),
    .pc_plus4              (pc_plus4),
    .fetch_busy            (fetch_busy),
    .instruction_valid     (instruction_valid),
`ifdef IMEM_TIMEOUT_EN
    .fetch_error           (fetch_error),
`endif
    .state_dbg             (state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m_pc, m_pc_cur, m_ir;
  bit          m_first, m_ready;
  logic [31:0] d_type, d_fc, d_rs1, d_rd, d_rs2, d_imm, d_stop;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Sign-extend the low n bits of v.
  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v & ((32'd1 << n) - 32'd1);
    if (r >= (32'd1 << (n - 1))) r = r - (32'd1 << n);
    return r;
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] w);
    int t;
    t = int'((w >> 1) & 32'd3);
    if (t == 0) return 32'd0;
    if (t == 3) return sext((w >> 3) & 32'hFF_FFFF, 24);
    return sext((w >> 3) & 32'h3FFF, 14);
  endfunction

  function automatic logic [31:0] model_next(input int src, input logic [31:0] bt,
                                             input logic [31:0] ra);
    if (m_first) return m_pc;
    case (src)
      0: return m_pc_cur + 32'd4;
      1: return bt;
      2: return m_pc_cur + sext((m_ir >> 3) & 32'hFF_FFFF, 24) * 32'd4;
      default: return ra;
    endcase
  endfunction

  task automatic model_decode();
    d_type = (m_ir >> 1) & 32'd3;
    d_fc   = m_ir >> 27;
    d_rs1  = (m_ir >> 22) & 32'd31;
    d_rd   = (m_ir >> 17) & 32'd31;
    d_rs2  = (m_ir >> 12) & 32'd31;
    d_imm  = model_imm(m_ir);
    d_stop = m_ir & 32'd1;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_pc_cur = RESET_PC; m_ir = 32'd0;
    m_first = 1'b1; m_ready = 1'b0;
    d_type = 0; d_fc = 0; d_rs1 = 0; d_rd = 0; d_rs2 = 0; d_imm = 0; d_stop = 0;
    exp_q.delete();
  endtask

  task automatic check_decode(input string tag);
    check({tag, "_type"}, {30'd0, InstructionType}, d_type);
    check({tag, "_fc"},   {27'd0, FunctionCode}, d_fc);
    check({tag, "_rs1"},  {27'd0, rs1}, d_rs1);
    check({tag, "_rd"},   {27'd0, rd}, d_rd);
    check({tag, "_rs2"},  {27'd0, rs2}, d_rs2);
    check({tag, "_imm"},  immediate, d_imm);
    check({tag, "_stop"}, {31'd0, stop_bit}, d_stop);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete fetch; ack arrives on REQ cycle number 'delay' (>= 1).
  task automatic do_fetch(input int src, input logic [31:0] bt, input logic [31:0] ra,
                          input logic [31:0] rdata, input int delay,
                          input bit with_decode, input bit extra_pulse);
    logic [31:0] a;
    exp_q.push_back(model_next(src, bt, ra));
    if (with_decode && m_ready) model_decode();
    en_instruction_fetch  = 1'b1;
    en_instruction_decode = with_decode;
    sig_pc_src = 2'(src); branch_target = bt; return_address = ra;
    tick();
    en_instruction_fetch = 1'b0; en_instruction_decode = 1'b0;
    m_first = 1'b0; m_ready = 1'b0;
    a = exp_q.pop_front();
    check("req_rise", {31'd0, imem_req}, 32'd1);
    check("busy_rise", {31'd0, fetch_busy}, 32'd1);
    check("valid_clr", {31'd0, instruction_valid}, 32'd0);
    check("imem_addr", imem_addr, a);
    if (with_decode) check_decode("dec_with_fetch");
    for (int i = 1; i < delay; i++) begin
      if (extra_pulse) begin
        en_instruction_fetch  = 1'b1;
        en_instruction_decode = 1'b1;
        sig_pc_src    = 2'($urandom_range(0, 3));
        branch_target = $urandom;
        return_address = $urandom;
      end
      imem_rdata = $urandom;
      tick();
      en_instruction_fetch = 1'b0; en_instruction_decode = 1'b0;
      check("req_hold", {31'd0, imem_req}, 32'd1);
      check("addr_hold", imem_addr, a);
      if (extra_pulse) check("imm_hold_in_req", immediate, d_imm);
    end
    imem_ack = 1'b1; imem_rdata = rdata;
    tick();
    imem_ack = 1'b0;
    check("req_drop", {31'd0, imem_req}, 32'd0);
    check("valid_set", {31'd0, instruction_valid}, 32'd1);
    check("pc_current", pc_current, a);
    check("pc_plus4", pc_plus4, a + 32'd4);
    m_pc = a; m_pc_cur = a; m_ir = rdata; m_ready = 1'b1;
  endtask

  task automatic do_decode();
    en_instruction_decode = 1'b1;
    tick();
    en_instruction_decode = 1'b0;
    if (m_ready) model_decode();
    check_decode("dec");
  endtask

  function automatic logic [31:0] rand_word_aligned();
    logic [31:0] w;
    w = $urandom;
    return {w[31:2], 2'b00};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", {31'd0, instruction_valid}, 32'd0);
    check("rst_busy", {31'd0, fetch_busy}, 32'd0);
    check("rst_pc_current", pc_current, RESET_PC);
    check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    check_decode("rst");
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // decode while IDLE is ignored
    do_decode();

    // first fetch always uses RESET_PC; minimum latency
    do_fetch(1, 32'h0000_0500, 32'd0, 32'h0884_6000, 1, 1'b0, 1'b0);
    do_decode();
    check("t1_fc", {27'd0, FunctionCode}, 32'd1);
    check("t1_rs1", {27'd0, rs1}, 32'd2);
    check("t1_rd", {27'd0, rd}, 32'd2);
    check("t1_rs2", {27'd0, rs2}, 32'd6);

    // sequential / branch / return selects
    do_fetch(1, 32'h0000_0010, 32'd0, $urandom, 1, 1'b0, 1'b0);
    do_fetch(0, 32'd0, 32'd0, $urandom, 2, 1'b0, 1'b0);
    check("seq_14", pc_current, 32'h14);
    do_fetch(1, 32'h0000_0200, 32'd0, $urandom, 1, 1'b0, 1'b0);
    do_fetch(3, 32'd0, 32'h0000_0044, $urandom, 1, 1'b0, 1'b0);
    check("ret_44", pc_current, 32'h44);

    // J-type with offset -1 at 0x100
    do_fetch(1, 32'h0000_0100, 32'd0, 32'h07FF_FFFE, 1, 1'b0, 1'b0);
    do_decode();
    check("j_imm", immediate, 32'hFFFF_FFFF);
    do_fetch(2, 32'd0, 32'd0, $urandom, 1, 1'b0, 1'b0);
    check("jump_fc", pc_current, 32'h0000_00FC);

    // ack on the 5th REQ cycle, stray fetch/decode pulses during REQ
    do_fetch(1, 32'h0000_0300, 32'd0, 32'h0001_0004, 5, 1'b0, 1'b1);
    do_decode();
    check("i_imm", immediate, 32'hFFFF_E000);

    // PC wrap-around
    do_fetch(1, 32'hFFFF_FFFC, 32'd0, $urandom, 1, 1'b0, 1'b0);
    check("wrap_plus4", pc_plus4, 32'd0);
    do_fetch(0, 32'd0, 32'd0, $urandom, 1, 1'b0, 1'b0);
    check("wrap_addr", pc_current, 32'd0);

    // J-type IR then simultaneous decode + jump fetch
    do_fetch(1, 32'h0000_1000, 32'd0, 32'h0000_0086, 1, 1'b0, 1'b0);
    do_fetch(2, 32'd0, 32'd0, $urandom, 2, 1'b1, 1'b0);
    check("sim_jump", pc_current, 32'h0000_1040);

    // ack outside REQ is ignored
    imem_ack = 1'b1; imem_rdata = ~m_ir;
    tick();
    imem_ack = 1'b0;
    check("stray_ack_req", {31'd0, imem_req}, 32'd0);
    check("stray_ack_valid", {31'd0, instruction_valid}, 32'd1);
    check("stray_ack_pc", pc_current, m_pc_cur);
    do_decode();

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      do_fetch(int'($urandom_range(0, 3)), rand_word_aligned(), rand_word_aligned(),
               $urandom, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) do_decode();
    end

    // asynchronous reset in the middle of REQ
    en_instruction_fetch = 1'b1; sig_pc_src = 2'd1; branch_target = 32'h0000_0800;
    tick();
    en_instruction_fetch = 1'b0;
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_req_drop", {31'd0, imem_req}, 32'd0);
    check("async_pc_current", pc_current, RESET_PC);
    check("async_valid", {31'd0, instruction_valid}, 32'd0);
    model_reset();
    check_decode("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    do_fetch(int'($urandom_range(0, 3)), 32'h0000_0900, 32'h0000_0A00, $urandom, 1,
             1'b0, 1'b0);
    check("post_rst_addr", pc_current, RESET_PC);

`ifdef IMEM_TIMEOUT_EN
    en_instruction_fetch = 1'b1; sig_pc_src = 2'd1; branch_target = 32'h0000_0C00;
    tick();
    en_instruction_fetch = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      check("tmo_req_hold", {31'd0, imem_req}, 32'd1);
    end
    tick();
    check("tmo_req_drop", {31'd0, imem_req}, 32'd0);
    check("tmo_error", {31'd0, fetch_error}, 32'd1);
    check("tmo_valid", {31'd0, instruction_valid}, 32'd1);
    m_pc = 32'h0000_0C00; m_pc_cur = 32'h0000_0C00; m_ir = 32'd0; m_ready = 1'b1;
    do_decode();
    do_fetch(0, 32'd0, 32'd0, $urandom, 1, 1'b0, 1'b0);
    check("tmo_error_clr", {31'd0, fetch_error}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard time bound
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
